data_detransposer: RTL and testbench

Reads a bit-plane-transposed result vector out of one MVU output RAM and rebuilds it as `NUM_WORDS` XLEN-bit integer words for the pito core, one word per valid/ready handshake. It is the read-side counterpart of `data_transposer`: one instance per MVU, between the MVU RAM read port and the pito SoC data path.

---
 rtl/mvu_pkg.sv | 25 ++
 rtl/mvu_rd_pipe.sv | 45 ++++
 rtl/data_detransposer.sv | 226 ++++++++++++++++++++++
 tb/tb_data_detransposer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared types and helpers for the MVU read-side data path.
package mvu_pkg;

  // Width of the precision field carried on the control interface.
  localparam int PREC_W        = 5;
  // Largest element precision a plane-buffer entry can hold.
  localparam int DETR_MAX_PREC = 16;

  // data_detransposer control states; exposed on dbg_state.
  typedef enum logic [1:0] {
    DETR_IDLE  = 2'd0,
    DETR_READ  = 2'd1,
    DETR_DRAIN = 2'd2,
    DETR_EMIT  = 2'd3
  } detr_state_t;

  // One element of the reconstructed vector, bit b = plane for weight 2^b.
  typedef logic [DETR_MAX_PREC-1:0] detr_entry_t;

  // A precision is usable when it is non-zero and fits the buffer entry.
  function automatic logic prec_legal(input logic [PREC_W-1:0] p, input int max_prec);
    return (p != '0) && (int'(p) <= max_prec);
  endfunction

endpackage

// File: rtl/mvu_rd_pipe.sv
// Delay line that follows each MVU RAM read through the fixed read latency,
// so the plane index arrives together with its return word.
module mvu_rd_pipe #(
  parameter int RD_LAT = 1,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]  idx_q [RD_LAT];
  logic [IDX_W-1:0]  idx_d [RD_LAT];

  // Shift the read strobe and its plane index one stage per cycle.
  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = in_valid;
    idx_d[0] = in_idx;
    for (int s = 1; s < RD_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      idx_d[s] = idx_q[s-1];
    end
  end

  // Reset empties the line so returns of aborted reads are never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) idx_q[s] <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/data_detransposer.sv
// Reads P bit-planes of a transposed vector from an MVU RAM and hands the
// rebuilt elements to the core one per valid/ready handshake.
//
// Handshake: an element transfers on every rising edge where o_valid and
// o_ready are both high; while o_valid is high and o_ready low, o_word,
// o_idx and o_last stay unchanged.
module data_detransposer
  import mvu_pkg::*;
#(
  parameter int NUM_WORDS     = 64,
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MVU_DATA_LEN  = 64,
  parameter int MAX_DATA_PREC = 16,
  parameter int RD_LAT        = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PREC_W-1:0]            prec,
  input  logic                         signed_en,
  input  logic [MVU_ADDR_LEN-1:0]      baddr,
  input  logic                         start,
  output logic                         busy,
  output logic                         err,
  output logic                         mvu_rd_en,
  output logic [MVU_ADDR_LEN-1:0]      mvu_rd_addr,
  input  logic [MVU_DATA_LEN-1:0]      mvu_rd_word,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [XLEN-1:0]              o_word,
  output logic [$clog2(NUM_WORDS)-1:0] o_idx,
  output logic                         o_last,
  output detr_state_t                  dbg_state
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  // Parameter sanity, caught at elaboration.
  if (MVU_DATA_LEN != NUM_WORDS) begin : g_bad_data_len
    $error("MVU_DATA_LEN must equal NUM_WORDS");
  end
  if (MAX_DATA_PREC > XLEN || MAX_DATA_PREC > DETR_MAX_PREC) begin : g_bad_prec
    $error("MAX_DATA_PREC exceeds XLEN or the plane-buffer entry width");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("RD_LAT must be at least 1");
  end
  if (NUM_WORDS < 2) begin : g_bad_words
    $error("NUM_WORDS must be at least 2");
  end

  detr_state_t              state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;
  logic                     rd_en_q, rd_en_d;
  logic [MVU_ADDR_LEN-1:0]  rd_addr_q, rd_addr_d;
  logic [PREC_W-1:0]        rd_plane_q, rd_plane_d;
  logic [PREC_W-1:0]        prec_q, prec_d;
  logic                     signed_q, signed_d;
  logic                     o_valid_q, o_valid_d;
  logic [IDX_W-1:0]         o_idx_q, o_idx_d;
  logic                     o_last_q, o_last_d;
  detr_entry_t              buf_q [NUM_WORDS];
  detr_entry_t              buf_d [NUM_WORDS];

  logic                     cap_valid;
  logic [PREC_W-1:0]        cap_plane;
  detr_entry_t              plane_mask;

  mvu_rd_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (PREC_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en_q),
    .in_idx    (rd_plane_q),
    .out_valid (cap_valid),
    .out_idx   (cap_plane)
  );

  // Next-state logic: plane capture into the buffer plus the control FSM.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    rd_plane_d = rd_plane_q;
    prec_d     = prec_q;
    signed_d   = signed_q;
    o_valid_d  = o_valid_q;
    o_idx_d    = o_idx_q;
    o_last_d   = o_last_q;
    buf_d      = buf_q;

    // Plane k (MSB first) lands at bit position P-1-k of every entry.
    plane_mask = '0;
    for (int b = 0; b < MAX_DATA_PREC; b++) begin
      if (b == int'(prec_q) - 1 - int'(cap_plane)) plane_mask[b] = 1'b1;
    end
    if (cap_valid) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        buf_d[i] = (buf_q[i] & ~plane_mask) | ({DETR_MAX_PREC{mvu_rd_word[i]}} & plane_mask);
      end
    end

    case (state_q)
      DETR_IDLE: begin
        if (start) begin
          if (prec_legal(prec, MAX_DATA_PREC)) begin
            state_d    = DETR_READ;
            busy_d     = 1'b1;
            rd_en_d    = 1'b1;
            rd_addr_d  = baddr;
            rd_plane_d = '0;
            prec_d     = prec;
            signed_d   = signed_en;
            for (int i = 0; i < NUM_WORDS; i++) buf_d[i] = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DETR_READ: begin
        if (rd_plane_q == prec_q - PREC_W'(1)) begin
          rd_en_d = 1'b0;
          state_d = DETR_DRAIN;
        end else begin
          rd_addr_d  = rd_addr_q + MVU_ADDR_LEN'(1);
          rd_plane_d = rd_plane_q + PREC_W'(1);
        end
      end
      DETR_DRAIN: begin
        if (cap_valid && cap_plane == prec_q - PREC_W'(1)) begin
          state_d   = DETR_EMIT;
          o_valid_d = 1'b1;
          o_idx_d   = '0;
          o_last_d  = 1'b0;
        end
      end
      DETR_EMIT: begin
        if (o_ready) begin
          if (o_last_q) begin
            state_d   = DETR_IDLE;
            busy_d    = 1'b0;
            o_valid_d = 1'b0;
            o_idx_d   = '0;
            o_last_d  = 1'b0;
          end else begin
            o_idx_d  = o_idx_q + IDX_W'(1);
            o_last_d = (o_idx_d == LAST_IDX);
          end
        end
      end
      default: state_d = DETR_IDLE;
    endcase
  end

  // Control registers; reset abandons any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DETR_IDLE;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_plane_q <= '0;
      prec_q     <= '0;
      signed_q   <= 1'b0;
      o_valid_q  <= 1'b0;
      o_idx_q    <= '0;
      o_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_plane_q <= rd_plane_d;
      prec_q     <= prec_d;
      signed_q   <= signed_d;
      o_valid_q  <= o_valid_d;
      o_idx_q    <= o_idx_d;
      o_last_q   <= o_last_d;
    end
  end

  // Plane buffer: pure datapath, cleared on every accepted start instead.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  detr_entry_t     cur_entry;
  logic            sign_bit;
  logic [XLEN-1:0] ext_word;

  // Extend the selected entry from P bits to XLEN; zero when nothing is offered.
  always_comb begin
    cur_entry = buf_q[o_idx_q];
    sign_bit  = 1'b0;
    for (int b = 0; b < MAX_DATA_PREC; b++) begin
      if (b == int'(prec_q) - 1) sign_bit = cur_entry[b];
    end
    sign_bit = sign_bit & signed_q;
    ext_word = '0;
    for (int b = 0; b < XLEN; b++) begin
      if (b >= int'(prec_q)) ext_word[b] = sign_bit;
    end
    for (int b = 0; b < MAX_DATA_PREC; b++) begin
      if (b < int'(prec_q)) ext_word[b] = cur_entry[b];
    end
    o_word = o_valid_q ? ext_word : '0;
  end

  assign busy        = busy_q;
  assign err         = err_q;
  assign mvu_rd_en   = rd_en_q;
  assign mvu_rd_addr = rd_addr_q;
  assign o_valid     = o_valid_q;
  assign o_idx       = o_idx_q;
  assign o_last      = o_last_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_data_detransposer.sv
// Bench for data_detransposer: RAM model with RD_LAT=2, randomized transfers,
// element values predicted from the bit-plane layout rules.
module tb_data_detransposer;
  import mvu_pkg::*;

  localparam int NW     = 64;
  localparam int XL     = 32;
  localparam int AW     = 15;
  localparam int DW     = 64;
  localparam int MAXP   = 16;
  localparam int RD_LAT = 2;
  localparam int EW     = 1 + 6 + XL;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]    prec = '0;
  logic          signed_en = 1'b0;
  logic [AW-1:0] baddr = '0;
  logic          start = 1'b0;
  logic          busy, err, mvu_rd_en, o_valid, o_last;
  logic [AW-1:0] mvu_rd_addr;
  logic [DW-1:0] mvu_rd_word;
  logic          o_ready = 1'b1;
  logic [XL-1:0] o_word;
  logic [5:0]    o_idx;
  detr_state_t   dbg_state;

  data_detransposer #(
    .NUM_WORDS(NW), .XLEN(XL), .MVU_ADDR_LEN(AW), .MVU_DATA_LEN(DW),
    .MAX_DATA_PREC(MAXP), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .prec(prec), .signed_en(signed_en), .baddr(baddr),
    .start(start), .busy(busy), .err(err), .mvu_rd_en(mvu_rd_en),
    .mvu_rd_addr(mvu_rd_addr), .mvu_rd_word(mvu_rd_word), .o_valid(o_valid),
    .o_ready(o_ready), .o_word(o_word), .o_idx(o_idx), .o_last(o_last),
    .dbg_state(dbg_state)
  );

  // MVU RAM model: fixed two-cycle read latency, junk when not reading.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rp0, rp1;
  always @(posedge clk) begin
    if (mvu_rd_en) rp0 <= mem[mvu_rd_addr];
    else           rp0 <= {$urandom, $urandom};
    rp1 <= rp0;
  end
  assign mvu_rd_word = rp1;

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int n_checks = 0;
  int n_pass = 0;
  bit rand_ready = 1'b0;
  logic [DW-1:0] pl [0:MAXP-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: element i is the P-bit number whose MSB comes from plane 0.
  function automatic logic [XL-1:0] ref_elem(input int i, input int p, input bit sg);
    longint v = 0;
    for (int k = 0; k < p; k++) v = v * 2 + longint'(pl[k][i]);
    if (sg && v >= (longint'(1) << (p - 1))) v = v - (longint'(1) << p);
    return XL'(v);
  endfunction

  // Consumer ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: read addresses, output handshakes, stall stability.
  logic          held_v = 1'b0;
  logic [EW-1:0] held;
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (mvu_rd_en) begin
        if (addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: got addr 0x%0h expected no read", mvu_rd_addr);
        end else begin
          check("rd_addr", 64'(mvu_rd_addr), 64'(addr_q.pop_front()));
        end
      end
      if (held_v && o_valid) check("stall_stable", 64'({o_last, o_idx, o_word}), 64'(held));
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL out_unexpected: got idx %0d word 0x%0h expected none", o_idx, o_word);
        end else begin
          check("out_elem", 64'({o_last, o_idx, o_word}), 64'(exp_q.pop_front()));
        end
      end
      held_v = o_valid && !o_ready;
      held   = {o_last, o_idx, o_word};
    end
  end

  // Driver: one transfer of the planes currently in pl[].
  task automatic run_xfer(input int p, input bit sg, input logic [AW-1:0] ba, input bit inject);
    int n;
    logic [AW-1:0] a;
    for (int k = 0; k < p; k++) begin
      a = ba + AW'(k);
      mem[a] = pl[k];
      addr_q.push_back(a);
    end
    for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), 6'(i), ref_elem(i, p, sg)});
    prec = 5'(p);
    signed_en = sg;
    baddr = ba;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    prec = 5'($urandom_range(0, 31));
    baddr = AW'($urandom);
    check("busy_rise", 64'(busy), 64'(1));
    check("first_rd_en", 64'(mvu_rd_en), 64'(1));
    n = 1;
    while (!o_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("valid_latency", 64'(n), 64'(p + RD_LAT + 1));
    if (inject) begin
      prec = 5'($urandom_range(1, MAXP));
      start = 1'b1;
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      check("start_ignored_err", 64'(err), 64'(0));
    end
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_fall", 64'(busy), 64'(0));
    if (!rand_ready) check("xfer_time", 64'(n), 64'(p + RD_LAT + NW + 1));
    check("exp_drained", 64'(exp_q.size()), 64'(0));
    check("addr_drained", 64'(addr_q.size()), 64'(0));
    check("idle_state", 64'(dbg_state), 64'(DETR_IDLE));
  endtask

  task automatic rand_planes(input int p);
    for (int k = 0; k < p; k++) pl[k] = {$urandom, $urandom};
  endtask

  task automatic bad_start(input logic [4:0] p);
    prec = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("err_pulse", 64'(err), 64'(1));
    check("err_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    check("err_clear", 64'(err), 64'(0));
    check("err_no_rd", 64'(mvu_rd_en), 64'(0));
  endtask

  initial begin
    int p;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rd_en", 64'(mvu_rd_en), 64'(0));
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_outs", 64'({o_word, o_idx, o_last, mvu_rd_addr}), 64'(0));

    // P=2 unsigned, fixed planes
    pl[0] = 64'h3;
    pl[1] = 64'h5;
    run_xfer(2, 1'b0, 15'h0010, 1'b0);

    // P=4, element 0 all ones, signed then unsigned
    rand_planes(4);
    for (int k = 0; k < 4; k++) pl[k][0] = 1'b1;
    run_xfer(4, 1'b1, 15'h0123, 1'b0);
    run_xfer(4, 1'b0, 15'h0456, 1'b0);

    // P=16 wrapping past the top of memory
    rand_planes(16);
    run_xfer(16, 1'b1, 15'h7FFE, 1'b0);

    // Random stalls plus a start during EMIT
    rand_ready = 1'b1;
    rand_planes(7);
    run_xfer(7, 1'b1, AW'($urandom), 1'b1);

    // Randomized transfers
    for (int t = 0; t < 6; t++) begin
      rand_ready = t[0];
      p = $urandom_range(1, MAXP);
      rand_planes(p);
      run_xfer(p, 1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;

    // Illegal precisions
    bad_start(5'd0);
    bad_start(5'd17);
    bad_start(5'd31);

    // Reset during the third read cycle, then an immediate P=1 transfer
    rand_planes(3);
    for (int k = 0; k < 3; k++) begin
      mem[15'h0200 + AW'(k)] = pl[k];
      addr_q.push_back(15'h0200 + AW'(k));
    end
    prec = 5'd3;
    baddr = 15'h0200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    addr_q.delete();
    exp_q.delete();
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_rd_en", 64'(mvu_rd_en), 64'(0));
    check("mid_rst_outs", 64'({o_valid, o_word, o_idx, o_last, err, mvu_rd_addr}), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(DETR_IDLE));
    rand_planes(1);
    run_xfer(1, 1'b1, 15'h0300, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
